// File: rtl/conv_encoder_mc.sv
// Multi-channel convolutional encoder: per-channel history, frame counting, zero-tail
// flush and optional puncturing, sharing a single configurable encoder datapath.
//
// state | meaning
// IDLE  | waiting for a configuration load
// RUN   | accepting info bits on any channel
// FLUSH | emitting K-1 zero-input tail symbols for the channel that finished its frame
module conv_encoder_mc #(
    parameter int NUM_CH    = 4,
    parameter int MAX_K     = 9,
    parameter int FRAME_LEN = 64
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      i_cfg_load,
    input  logic                      i_code_rate,
    input  logic [3:0]                i_constr_len,
    input  logic [3*MAX_K-1:0]        i_gen_poly,
    input  logic                      i_punct_en,
    input  logic [5:0]                i_punct_pat,
    input  logic                      i_valid,
    input  logic [$clog2(NUM_CH)-1:0] i_ch,
    input  logic                      i_bit,
    output logic                      o_ready,
    output logic                      o_valid,
    output logic [$clog2(NUM_CH)-1:0] o_ch,
    output logic [2:0]                o_data,
    output logic [2:0]                o_mask,
    output logic                      o_last,
    output logic                      o_cfg_err
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int HW    = MAX_K - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                 cfg_rate;
    logic [3:0]           cfg_k;
    logic [3*MAX_K-1:0]   cfg_poly;
    logic                 cfg_punct_en;
    logic [5:0]           cfg_punct_pat;

    logic [HW-1:0]        hist_q [NUM_CH];
    logic [CNT_W-1:0]     cnt_q  [NUM_CH];
    logic [NUM_CH-1:0]    phase_q;
    logic [CH_W-1:0]      flush_ch_q;
    logic [3:0]           tail_left_q;

    logic                 valid_q;
    logic                 last_q;
    logic                 cfg_err_q;
    logic [CH_W-1:0]      ch_q;
    logic [2:0]           data_q;
    logic [2:0]           mask_q;

    logic [CH_W-1:0]      enc_ch;
    logic                 enc_bit;
    logic [MAX_K-1:0]     window;
    logic [MAX_K-1:0]     kmask;
    logic [2:0]           enc_data;
    logic [2:0]           enc_mask;
    logic [2:0]           rate_mask;
    logic [2:0]           punct_mask;

    logic                 k_legal;
    logic                 load_ok;
    logic                 cfg_err_d;
    logic                 fire;
    logic                 frame_end;
    logic                 tail_end;

    // During FLUSH the shared datapath is steered to the flushing channel with a 0 input.
    always_comb begin
        enc_ch  = i_ch;
        enc_bit = i_bit;
        if (state_q == S_FLUSH) begin
            enc_ch  = flush_ch_q;
            enc_bit = 1'b0;
        end
    end

    always_comb begin
        window   = {hist_q[enc_ch], enc_bit};
        kmask    = '0;
        enc_data = '0;
        for (int m = 0; m < MAX_K; m++) begin
            kmask[m] = (4'(m) < cfg_k);
        end
        for (int j = 0; j < 3; j++) begin
            enc_data[j] = ^(cfg_poly[j*MAX_K +: MAX_K] & window & kmask);
        end
        if (!cfg_rate) begin
            enc_data[2] = 1'b0;
        end
        rate_mask  = cfg_rate ? 3'b111 : 3'b011;
        punct_mask = phase_q[enc_ch] ? cfg_punct_pat[5:3] : cfg_punct_pat[2:0];
        enc_mask   = cfg_punct_en ? (rate_mask & punct_mask) : rate_mask;
    end

    always_comb begin
        state_d   = state_q;
        load_ok   = 1'b0;
        cfg_err_d = 1'b0;
        fire      = 1'b0;
        frame_end = 1'b0;
        tail_end  = 1'b0;
        k_legal   = (i_constr_len >= 4'd3) && (i_constr_len <= 4'(MAX_K));
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (i_cfg_load) begin
                        if (k_legal) begin
                            load_ok = 1'b1;
                            state_d = S_RUN;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (i_valid) begin
                        fire = 1'b1;
                        if (cnt_q[enc_ch] == CNT_W'(FRAME_LEN - 1)) begin
                            frame_end = 1'b1;
                            state_d   = S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    fire = 1'b1;
                    if (tail_left_q == 4'd1) begin
                        tail_end = 1'b1;
                        state_d  = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cfg_rate      <= 1'b0;
            cfg_k         <= '0;
            cfg_poly      <= '0;
            cfg_punct_en  <= 1'b0;
            cfg_punct_pat <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                hist_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            phase_q       <= '0;
            flush_ch_q    <= '0;
            tail_left_q   <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            ch_q          <= '0;
            data_q        <= '0;
            mask_q        <= '0;
        end else if (en) begin
            state_q   <= state_d;
            valid_q   <= fire;
            last_q    <= tail_end;
            cfg_err_q <= cfg_err_d;
            if (load_ok) begin
                cfg_rate      <= i_code_rate;
                cfg_k         <= i_constr_len;
                cfg_poly      <= i_gen_poly;
                cfg_punct_en  <= i_punct_en;
                cfg_punct_pat <= i_punct_pat;
            end
            if (fire) begin
                ch_q   <= enc_ch;
                data_q <= enc_data;
                mask_q <= enc_mask;
                if (tail_end) begin
                    hist_q[enc_ch]  <= '0;
                    cnt_q[enc_ch]   <= '0;
                    phase_q[enc_ch] <= 1'b0;
                end else begin
                    hist_q[enc_ch]  <= window[HW-1:0];
                    phase_q[enc_ch] <= ~phase_q[enc_ch];
                    if (state_q == S_RUN) begin
                        cnt_q[enc_ch] <= cnt_q[enc_ch] + 1'b1;
                    end
                end
            end
            if (frame_end) begin
                flush_ch_q  <= enc_ch;
                tail_left_q <= cfg_k - 4'd1;
            end else if ((state_q == S_FLUSH) && fire) begin
                tail_left_q <= tail_left_q - 4'd1;
            end
        end
    end

    // Pending outputs are masked while disabled and appear once enable returns.
    assign o_ready   = en && (state_q == S_RUN);
    assign o_valid   = valid_q & en;
    assign o_last    = last_q & en;
    assign o_cfg_err = cfg_err_q & en;
    assign o_ch      = ch_q;
    assign o_data    = data_q;
    assign o_mask    = mask_q;

endmodule
